// File: rtl/ex_div_ctrl.sv
// Multi-cycle 32-bit divider controller for the EX stage: FREE/BYZERO/ON/END FSM
// driving a restoring shift-subtract core, one quotient bit per cycle.
module ex_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic                ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W:0]     shl;
  logic [DATA_W:0]     diff;
  logic                sa, sb;

  // Partial remainder shifted left with the next dividend bit pulled in from quo_q.
  assign shl  = {rem_q, quo_q[DATA_W-1]};
  assign diff = shl - {1'b0, dvs_q};
  assign sa   = signed_div_i & opdata1_i[DATA_W-1];
  assign sb   = signed_div_i & opdata2_i[DATA_W-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    ready_d  = 1'b0;
    result_d = '0;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          quo_d   = sa ? -opdata1_i : opdata1_i;
          dvs_d   = sb ? -opdata2_i : opdata2_i;
          rem_d   = '0;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          cnt_d   = '0;
          state_d = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        // Zeroed datapath makes the END fixup produce an all-zero result.
        quo_d   = '0;
        rem_d   = '0;
        dvs_d   = '0;
        negq_d  = 1'b0;
        negr_d  = 1'b0;
        state_d = END;
      end
      ON: begin
        if (annul_i) begin
          cnt_d   = '0;
          state_d = FREE;
        end else begin
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shl[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            cnt_d   = '0;
            state_d = END;
          end
        end
      end
      END: begin
        if (start_i) begin
          ready_d  = 1'b1;
          result_d = {negr_q ? -rem_q : rem_q, negq_q ? -quo_q : quo_q};
        end else begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = ~rst & start_i & ~annul_i & ~ready_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: latency, signed/unsigned results, div-by-zero,
// annul, reset mid-iteration and END hold behaviour.
module tb_ex_div_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int failures = 0;

  ex_div_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept a division, scramble operands, wait bounded for ready_o, check
  // latency/result/stall, then hold start a few cycles and release it.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    logic stall_ok;
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    #1;
    chk({tag, "_stall_pre"}, {63'd0, stallreq_o}, 64'd1);
    tick();
    opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0003; signed_div_i = ~sgn;
    n = 0;
    stall_ok = 1'b1;
    while (n < 40) begin
      if (stallreq_o !== 1'b1 || result_o !== 64'd0) stall_ok = 1'b0;
      tick();
      n++;
      if (ready_o === 1'b1) break;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy_outs"}, {63'd0, stall_ok}, 64'd1);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_stall_done"}, {63'd0, stallreq_o}, 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    start_i = 1'b0;
    tick();
    chk({tag, "_release"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_release_res"}, result_o, 64'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd1;
    start_i = 1'b1; annul_i = 1'b0;
    tick(); tick();
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
    start_i = 1'b0; rst = 1'b0;
    tick();

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    run_div("u_big", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF}, 33);
    run_div("u_div0", 1'b0, 32'd123, 32'd0, 64'd0, 2);
    run_div("s_div0", 1'b1, 32'hFFFF_FF00, 32'd0, 64'd0, 2);

    // start and annul together in FREE: nothing accepted, no stall.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    #1;
    chk("annul_free_stall", {63'd0, stallreq_o}, 64'd0);
    tick(); tick(); tick();
    annul_i = 1'b0; start_i = 1'b0;
    run_div("after_annul", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

    // Annul at iteration 10.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("annul_no_ready", {63'd0, seen}, 64'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Reset at iteration 20 with start held through reset.
    opdata1_i = 32'd77; opdata2_i = 32'd4; start_i = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {63'd0, stallreq_o}, 64'd0);
    tick();
    chk("rst_mid_outs", {ready_o, result_o[62:0]}, 64'd0);
    tick();
    rst = 1'b0;
    run_div("post_rst", 1'b0, 32'd77, 32'd4, {32'd1, 32'd19}, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
